// File: rtl/elastic_pipe_register_if.sv
// Handshake bundle between an elastic pipe and its producer/consumer.
// The slave modport is the pipe itself; the master modport is the surrounding datapath.
interface elastic_pipe_register_if #(
    parameter int WORD_LENGTH = 5,
    parameter int DEPTH       = 2
);
    localparam int OCC_WIDTH = $clog2(DEPTH + 1);

    logic                   in_valid;
    logic                   in_ready;
    logic [WORD_LENGTH-1:0] Data_Input;
    logic                   out_valid;
    logic                   out_ready;
    logic [WORD_LENGTH-1:0] Data_Output;
    logic [OCC_WIDTH-1:0]   occupancy;

    modport slave (
        input  in_valid,
        input  Data_Input,
        input  out_ready,
        output in_ready,
        output out_valid,
        output Data_Output,
        output occupancy
    );

    modport master (
        output in_valid,
        output Data_Input,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Data_Output,
        input  occupancy
    );
endinterface

// File: rtl/elastic_pipe_register.sv
// DEPTH-stage valid/ready register chain clocked on the falling edge of clk.
// Bubbles collapse under back-pressure, flush clears everything, occupancy counts valid stages.
module elastic_pipe_register #(
    parameter int  WORD_LENGTH = 5,
    parameter int  DEPTH       = 2,
    localparam int OCC_WIDTH   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    elastic_pipe_register_if.slave    bus
);

    logic [WORD_LENGTH-1:0] data_q   [DEPTH];
    logic [DEPTH-1:0]       valid_q;
    logic [DEPTH-1:0]       stage_ready;
    logic [DEPTH-1:0]       up_valid;
    logic [WORD_LENGTH-1:0] up_data  [DEPTH];
    logic [OCC_WIDTH-1:0]   occ_count;

    // A stage may load when it is empty or everything downstream of it can move.
    always_comb begin
        logic chain;
        // NOTE: blocking assignments here are intentional; chain is a running value
        // walked from the output end back to stage 0 within one evaluation.
        chain = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            chain          = !valid_q[i] | chain;
            stage_ready[i] = chain;
        end
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a value before any branch or
        // loop touches it, so no path leaves it unassigned and no latch is inferred.
        up_valid    = '0;
        up_data     = '{default: '0};
        up_valid[0] = bus.in_valid;
        up_data[0]  = bus.Data_Input;
        for (int i = 1; i < DEPTH; i++) begin
            up_valid[i] = valid_q[i-1];
            up_data[i]  = data_q[i-1];
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            // NOTE: the data registers are cleared too, not just the valid bits, because
            // Data_Output must read zero after reset and flush, not a stale word.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (stage_ready[i]) begin
                    valid_q[i] <= up_valid[i];
                    // A bubble moving in leaves the old data untouched.
                    if (up_valid[i]) begin
                        data_q[i] <= up_data[i];
                    end
                end
            end
        end
    end

    always_comb begin
        occ_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_count = occ_count + OCC_WIDTH'(valid_q[i]);
        end
    end

    assign bus.in_ready    = stage_ready[0];
    assign bus.out_valid   = valid_q[DEPTH-1];
    assign bus.Data_Output = data_q[DEPTH-1];
    assign bus.occupancy   = occ_count;

endmodule

// File: tb/tb_elastic_pipe_register.sv
// Bench for elastic_pipe_register (WORD_LENGTH=8, DEPTH=3): directed vector table,
// hand-written corner sequences, then random traffic against a word-position queue model.
module tb_elastic_pipe_register;

    localparam int WL    = 8;
    localparam int DEPTH = 3;

    logic clk   = 1'b1;
    logic reset = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    elastic_pipe_register_if #(.WORD_LENGTH(WL), .DEPTH(DEPTH)) bus ();

    elastic_pipe_register #(.WORD_LENGTH(WL), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic [WL-1:0] ed,
                              input logic [1:0] eo, input logic er);
        check({tag, " out_valid"},   32'(bus.out_valid),   32'(ev));
        check({tag, " Data_Output"}, 32'(bus.Data_Output), 32'(ed));
        check({tag, " occupancy"},   32'(bus.occupancy),   32'(eo));
        check({tag, " in_ready"},    32'(bus.in_ready),    32'(er));
    endtask

    // Apply inputs for one falling edge, then settle just after it.
    task automatic step(input logic iv, input logic [WL-1:0] d, input logic ordy, input logic fl);
        bus.in_valid   = iv;
        bus.Data_Input = d;
        bus.out_ready  = ordy;
        flush          = fl;
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic          in_valid;
        logic [WL-1:0] din;
        logic          out_ready;
        logic          exp_valid;
        logic [WL-1:0] exp_data;
        logic [1:0]    exp_occ;
        logic          exp_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic iv, input logic [WL-1:0] d, input logic ordy,
                                input logic ev, input logic [WL-1:0] ed,
                                input logic [1:0] eo, input logic er);
        vec_t v;
        v.in_valid  = iv;
        v.din       = d;
        v.out_ready = ordy;
        v.exp_valid = ev;
        v.exp_data  = ed;
        v.exp_occ   = eo;
        v.exp_ready = er;
        vecs.push_back(v);
    endfunction

    // Reference model: each stored word knows which stage it sits in. A word moves up one
    // stage unless every stage above it is full and the consumer is stalling.
    typedef struct {
        logic [WL-1:0] data;
        int            pos;
    } entry_t;

    entry_t        mq[$];
    logic [WL-1:0] m_last;

    function automatic void model_edge(input logic iv, input logic [WL-1:0] d,
                                       input logic ordy, input logic fl);
        bit     accept;
        entry_t e;
        if (fl) begin
            mq.delete();
            m_last = '0;
            return;
        end
        accept = iv && !(mq.size() == DEPTH && !ordy);
        if (ordy) begin
            if (mq.size() > 0 && mq[0].pos == DEPTH - 1) begin
                void'(mq.pop_front());
            end
            foreach (mq[k]) mq[k].pos++;
        end else begin
            foreach (mq[k]) begin
                if (mq[k].pos < DEPTH - 1 - k) mq[k].pos++;
            end
        end
        if (accept) begin
            e.data = d;
            e.pos  = 0;
            mq.push_back(e);
        end
        foreach (mq[k]) begin
            if (mq[k].pos == DEPTH - 1) m_last = mq[k].data;
        end
    endfunction

    task automatic model_step(input string tag, input logic iv, input logic [WL-1:0] d,
                              input logic ordy, input logic fl);
        logic ev;
        step(iv, d, ordy, fl);
        model_edge(iv, d, ordy, fl);
        ev = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
        check_outs(tag, ev, m_last, 2'(mq.size()), !(mq.size() == DEPTH && !ordy));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, expected to have finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.Data_Input = '0;
        bus.out_ready  = 1'b0;

        // Reset state, while held and after release.
        repeat (3) @(negedge clk);
        #1;
        check_outs("in_reset", 1'b0, 8'h00, 2'd0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_outs("after_reset", 1'b0, 8'h00, 2'd0, 1'b1);

        // Streaming with out_ready=1, then back-pressure with out_ready=0.
        add(1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 2'd1, 1'b1);
        add(1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 2'd2, 1'b1);
        add(1'b1, 8'h33, 1'b1, 1'b1, 8'h11, 2'd3, 1'b1);
        add(1'b1, 8'h44, 1'b1, 1'b1, 8'h22, 2'd3, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 2'd2, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 2'd1, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 8'h44, 2'd0, 1'b1);
        add(1'b1, 8'hA1, 1'b0, 1'b0, 8'h44, 2'd1, 1'b1);
        add(1'b1, 8'hA2, 1'b0, 1'b0, 8'h44, 2'd2, 1'b1);
        add(1'b1, 8'hA3, 1'b0, 1'b1, 8'hA1, 2'd3, 1'b0);
        add(1'b1, 8'hA4, 1'b0, 1'b1, 8'hA1, 2'd3, 1'b0);
        add(1'b1, 8'hA5, 1'b0, 1'b1, 8'hA1, 2'd3, 1'b0);
        add(1'b1, 8'hA4, 1'b0, 1'b1, 8'hA1, 2'd3, 1'b0);
        add(1'b1, 8'hA4, 1'b0, 1'b1, 8'hA1, 2'd3, 1'b0);
        add(1'b1, 8'hA4, 1'b0, 1'b1, 8'hA1, 2'd3, 1'b0);
        add(1'b1, 8'hA4, 1'b1, 1'b1, 8'hA2, 2'd3, 1'b1);
        add(1'b1, 8'hA5, 1'b1, 1'b1, 8'hA3, 2'd3, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 2'd2, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 2'd1, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 2'd0, 1'b1);

        foreach (vecs[i]) begin
            step(vecs[i].in_valid, vecs[i].din, vecs[i].out_ready, 1'b0);
            check_outs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                       vecs[i].exp_occ, vecs[i].exp_ready);
        end

        // Bubble collapse under out_ready=0.
        step(1'b1, 8'h10, 1'b0, 1'b0);
        check("bubble occ_1", 32'(bus.occupancy), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_outs("bubble head", 1'b1, 8'h10, 2'd1, 1'b1);
        step(1'b1, 8'h20, 1'b0, 1'b0);
        check_outs("bubble second", 1'b1, 8'h10, 2'd2, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check_outs("bubble collapse", 1'b1, 8'h10, 2'd2, 1'b1);
        step(1'b1, 8'h30, 1'b0, 1'b0);
        check_outs("bubble full", 1'b1, 8'h10, 2'd3, 1'b0);

        // Flush at occupancy 2 with a valid input on the same edge.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check_outs("pre_flush", 1'b1, 8'h20, 2'd2, 1'b1);
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        check_outs("flush", 1'b0, 8'h00, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check($sformatf("post_flush%0d out_valid", i), 32'(bus.out_valid), 32'd0);
            check($sformatf("post_flush%0d occupancy", i), 32'(bus.occupancy), 32'd0);
        end

        // Asynchronous reset between edges with a full pipe.
        step(1'b1, 8'hB1, 1'b0, 1'b0);
        step(1'b1, 8'hB2, 1'b0, 1'b0);
        step(1'b1, 8'hB3, 1'b0, 1'b0);
        check_outs("pre_async", 1'b1, 8'hB1, 2'd3, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_outs("async_reset", 1'b0, 8'h00, 2'd0, 1'b1);
        #1;
        reset = 1'b1;

        // Recovery stream and random traffic against the model.
        mq.delete();
        m_last = '0;
        model_step("recover0", 1'b1, 8'h5A, 1'b1, 1'b0);
        model_step("recover1", 1'b1, 8'h5B, 1'b1, 1'b0);
        model_step("recover2", 1'b0, 8'h00, 1'b1, 1'b0);
        check("recover latency", 32'(bus.Data_Output), 32'h5A);
        for (int i = 0; i < 400; i++) begin
            logic          iv;
            logic          ordy;
            logic          fl;
            logic [WL-1:0] d;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 31) == 0);
            d    = WL'($urandom);
            model_step($sformatf("rand%0d", i), iv, d, ordy, fl);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
